// File: rtl/buffered_uart_tx.sv
// Transmit-only 8N1 UART behind a byte FIFO.
// Bytes strobed in on data_valid are queued and serialised LSB first at
// CLKS_PER_BIT clocks per bit. Writes arriving while the FIFO is full are
// dropped without side effects. dbg_state exposes the transmitter FSM state.
//
// Handshake: data_valid is a write strobe with no ready; every cycle it is
// high and full is low (pre-edge) stores one byte. full is the only
// back-pressure indication and the caller may ignore it.
module buffered_uart_tx #(
    parameter int CLKS_PER_BIT = 416,
    parameter int ADDR_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       full,
    output logic       uart_tx,
    output logic [1:0] dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              wr_en;
    logic              pop;
    logic              bit_done;

    // full derives from the registered count, so it reflects the edge that changed it
    assign full      = (count_q == (ADDR_W+1)'(DEPTH));
    assign wr_en     = data_valid & ~full;
    assign bit_done  = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign uart_tx   = tx_q;
    assign dbg_state = state_q;

    // FIFO storage: contents are not reset, only pointers and count are
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    // FIFO pointer and occupancy update; pointers wrap naturally at 2^ADDR_W
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Transmitter next-state: IDLE pops the head, then START, 8 DATA bits, STOP
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    tx_d      = 1'b0;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // shift_q[0] is on the line; expose the next bit
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State registers; reset aborts any frame and returns the line high at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_buffered_uart_tx.sv
// Bench for buffered_uart_tx: two instances share the clock, channel 0 with a
// 64-byte FIFO and channel 1 with a 4-byte FIFO, both at 4 clocks per bit.
// A queue-based model decides per edge which bytes are accepted and when each
// frame starts; a line monitor compares every sampled uart_tx level against
// the frame the model expects and decodes the byte at bit centres.
module tb_buffered_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic [1:0] rst_v;
  logic [1:0] valid_v;
  logic [7:0] data_v [2];
  logic [1:0] tx_v;
  logic [1:0] full_v;
  logic [1:0] st0, st1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // model state per channel
  logic [7:0] m_fifo   [2][$];
  int         fr_start [2][$];
  logic [7:0] fr_byte  [2][$];
  int         next_pop [2];

  // monitor state per channel
  logic       mon_act     [2];
  int         mon_start   [2];
  logic [7:0] mon_byte    [2];
  logic [7:0] mon_dec     [2];
  int         mon_bad     [2];
  int         idle_bad    [2];
  int         full_bad    [2];
  int         frames_done [2];

  always #5 clk = ~clk;

  buffered_uart_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(6)) dut_a (
    .clk(clk), .rst(rst_v[0]), .data(data_v[0]), .data_valid(valid_v[0]),
    .full(full_v[0]), .uart_tx(tx_v[0]), .dbg_state(st0)
  );

  buffered_uart_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst_v[1]), .data(data_v[1]), .data_valid(valid_v[1]),
    .full(full_v[1]), .uart_tx(tx_v[1]), .dbg_state(st1)
  );

  function automatic int depth_of(input int ch);
    return (ch == 0) ? 64 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a byte is accepted when fewer than depth bytes wait;
  // the transmitter takes the head whenever bytes wait and the previous
  // frame plus its one idle cycle is over.
  initial begin
    int   n;
    int   sz;
    logic do_pop;
    logic do_wr;
    for (int ch = 0; ch < 2; ch++) next_pop[ch] = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      n   = cyc;
      for (int ch = 0; ch < 2; ch++) begin
        if (!rst_v[ch]) begin
          m_fifo[ch].delete();
          fr_start[ch].delete();
          fr_byte[ch].delete();
          next_pop[ch] = 0;
        end else begin
          sz     = m_fifo[ch].size();
          do_pop = (sz > 0) && (n >= next_pop[ch]);
          do_wr  = valid_v[ch] && (sz < depth_of(ch));
          if (do_pop) begin
            fr_start[ch].push_back(n);
            fr_byte[ch].push_back(m_fifo[ch].pop_front());
            next_pop[ch] = n + FRAME + 1;
          end
          if (do_wr) m_fifo[ch].push_back(data_v[ch]);
        end
      end
    end
  end

  // Line monitor: sample every cycle on the falling clock edge
  initial begin
    int   off;
    int   bi;
    logic exp_bit;
    for (int ch = 0; ch < 2; ch++) begin
      mon_act[ch] = 1'b0; mon_start[ch] = 0; mon_byte[ch] = '0; mon_dec[ch] = '0;
      mon_bad[ch] = 0; idle_bad[ch] = 0; full_bad[ch] = 0; frames_done[ch] = 0;
    end
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
        if (!rst_v[ch]) begin
          mon_act[ch] = 1'b0;
          if (tx_v[ch] !== 1'b1) idle_bad[ch]++;
          if (full_v[ch] !== 1'b0) full_bad[ch]++;
        end else begin
          if (full_v[ch] !== (m_fifo[ch].size() == depth_of(ch))) full_bad[ch]++;
          if (!mon_act[ch] && fr_start[ch].size() > 0 && fr_start[ch][0] == cyc) begin
            mon_start[ch] = fr_start[ch].pop_front();
            mon_byte[ch]  = fr_byte[ch].pop_front();
            mon_bad[ch]   = 0;
            mon_dec[ch]   = '0;
            mon_act[ch]   = 1'b1;
          end
          if (mon_act[ch]) begin
            off = cyc - mon_start[ch];
            bi  = off / CPB;
            if (bi == 0)      exp_bit = 1'b0;
            else if (bi == 9) exp_bit = 1'b1;
            else              exp_bit = mon_byte[ch][3'(bi - 1)];
            if (tx_v[ch] !== exp_bit) mon_bad[ch]++;
            if (bi >= 1 && bi <= 8 && (off % CPB) == CPB / 2)
              mon_dec[ch][3'(bi - 1)] = tx_v[ch];
            if (off == FRAME - 1) begin
              chk($sformatf("frame_line_ch%0d", ch), mon_bad[ch], 0);
              chk($sformatf("frame_byte_ch%0d", ch), {24'd0, mon_dec[ch]}, {24'd0, mon_byte[ch]});
              frames_done[ch]++;
              mon_act[ch] = 1'b0;
            end
          end else if (tx_v[ch] !== 1'b1) begin
            idle_bad[ch]++;
          end
        end
      end
    end
  end

  task automatic wait_drain(input int ch, input int budget, input string tag);
    int k;
    k = 0;
    while (!(m_fifo[ch].size() == 0 && fr_start[ch].size() == 0 && !mon_act[ch]
             && cyc >= next_pop[ch]) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_in_budget"}, (k < budget), 1);
    chk({tag, "_line_idle"}, tx_v[ch], 1);
    chk({tag, "_state_idle"}, (ch == 0) ? st0 : st1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int         k;
    int         f0;
    int         sent;
    int         nb;
    logic       ok;
    logic [7:0] seq3 [3];
    seq3[0] = 8'h31; seq3[1] = 8'h00; seq3[2] = 8'hFF;

    rst_v      = 2'b00;
    valid_v    = 2'b00;
    data_v[0]  = '0;
    data_v[1]  = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx0", tx_v[0], 1);
    chk("rst_tx1", tx_v[1], 1);
    chk("rst_full0", full_v[0], 0);
    chk("rst_full1", full_v[1], 0);
    chk("rst_state0", st0, 0);
    rst_v = 2'b11;
    repeat (2) @(negedge clk);

    // single byte 0xA5: line falls one edge after the write edge
    data_v[0] = 8'hA5; valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    chk("a5_before_start", tx_v[0], 1);
    @(negedge clk);
    chk("a5_start_bit", tx_v[0], 0);
    f0 = frames_done[0];
    wait_drain(0, 200, "a5");
    chk("a5_frames", frames_done[0] - f0, 1);

    // three back-to-back writes
    f0 = frames_done[0];
    for (int i = 0; i < 3; i++) begin
      data_v[0] = seq3[i]; valid_v[0] = 1'b1;
      @(negedge clk);
    end
    valid_v[0] = 1'b0;
    chk("seq3_full", full_v[0], 0);
    wait_drain(0, 400, "seq3");
    chk("seq3_frames", frames_done[0] - f0, 3);

    // fill the 4-deep FIFO: 0x01..0x05 accepted, 0x06 dropped
    f0 = frames_done[1];
    for (int i = 1; i <= 6; i++) begin
      data_v[1] = 8'(i); valid_v[1] = 1'b1;
      @(negedge clk);
    end
    valid_v[1] = 1'b0;
    chk("fill_full", full_v[1], 1);
    k = 0;
    while (cyc != next_pop[1] - 1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("fill_pop_wait", (k < 200), 1);
    chk("pre_pop_full", full_v[1], 1);
    // write on the same edge the transmitter pops: must be rejected
    data_v[1] = 8'h77; valid_v[1] = 1'b1;
    @(negedge clk);
    valid_v[1] = 1'b0;
    chk("pop_edge_full", full_v[1], 0);
    chk("pop_edge_start", tx_v[1], 0);
    wait_drain(1, 600, "fill");
    chk("fill_frames", frames_done[1] - f0, 5);

    // random strobes into the small FIFO, with drops when full
    repeat (40) begin
      data_v[1]  = 8'($urandom);
      valid_v[1] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    valid_v[1] = 1'b0;
    wait_drain(1, 2000, "rand");

    // reset in the middle of a data bit while three bytes wait
    for (int i = 0; i < 4; i++) begin
      data_v[0]  = (i == 0) ? 8'h00 : 8'($urandom);
      valid_v[0] = 1'b1;
      @(negedge clk);
    end
    valid_v[0] = 1'b0;
    k = 0;
    while (cyc < next_pop[0] - FRAME - 1 + 3 * CPB + 1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("mid_frame_low", tx_v[0], 0);
    @(posedge clk);
    #1;
    rst_v[0] = 1'b0;
    #1;
    chk("abort_tx_high", tx_v[0], 1);
    chk("abort_full", full_v[0], 0);
    repeat (2) @(negedge clk);
    rst_v[0] = 1'b1;
    ok = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1) ok = 1'b0;
    end
    chk("post_reset_quiet", ok, 1);
    f0 = frames_done[0];
    data_v[0] = 8'($urandom); valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    wait_drain(0, 200, "post_reset");
    chk("post_reset_frames", frames_done[0] - f0, 1);

    // 70 bytes in bursts of 8, one frame apart: wraps the 64-entry pointers
    f0   = frames_done[0];
    sent = 0;
    while (sent < 70) begin
      nb = (70 - sent < 8) ? 70 - sent : 8;
      for (int i = 0; i < nb; i++) begin
        data_v[0] = 8'($urandom); valid_v[0] = 1'b1;
        @(negedge clk);
      end
      valid_v[0] = 1'b0;
      sent += nb;
      repeat (FRAME) @(negedge clk);
    end
    wait_drain(0, 5000, "burst70");
    chk("burst70_frames", frames_done[0] - f0, 70);

    chk("idle_line_ch0", idle_bad[0], 0);
    chk("idle_line_ch1", idle_bad[1], 0);
    chk("full_track_ch0", full_bad[0], 0);
    chk("full_track_ch1", full_bad[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
